// File: rtl/sdram_port_arbiter.sv
// ---------------------------------------------------------------------------
// sdram_port_arbiter
//
// Shares the byte-wide SDRAM port between the HC800 CPU RAM bus and the
// program uploader. CPU cycles always own the port and keep their one-cycle
// read latency. Upload bytes are queued in a small FIFO and written into
// cycles the CPU leaves idle. A session FSM holds the CPU off the bus from
// the start of an upload until every queued byte has been committed.
//
// Ports
//   bus_clk, bus_reset_n   clock, asynchronous active-low reset
//   cpu_enable/write/      CPU access request, direction, address, write data
//   cpu_address/wdata
//   cpu_rdata              registered read data (0 after a non-read cycle)
//   cpu_hold               CPU hold request while a session is loading/draining
//   up_active/strobe/      uploader session level, byte strobe, offset, data
//   up_addr/data
//   up_overflow            sticky: a byte was dropped in this session
//   up_done                one-cycle pulse once the session has drained
//   up_count               bytes committed in this session
//   mem_enable/write/      combinational SDRAM request
//   mem_address/wdata
//   mem_rdata              SDRAM read data for this cycle's access
// ---------------------------------------------------------------------------
module sdram_port_arbiter #(
    parameter int          UP_AW       = 12,
    parameter logic [20:0] UPLOAD_BASE = 21'h000000,
    parameter int          FIFO_DEPTH  = 4
) (
    input  logic             bus_clk,
    input  logic             bus_reset_n,
    input  logic             cpu_enable,
    input  logic             cpu_write,
    input  logic [20:0]      cpu_address,
    input  logic [7:0]       cpu_wdata,
    output logic [7:0]       cpu_rdata,
    output logic             cpu_hold,
    input  logic             up_active,
    input  logic             up_strobe,
    input  logic [UP_AW-1:0] up_addr,
    input  logic [7:0]       up_data,
    output logic             up_overflow,
    output logic             up_done,
    output logic [20:0]      up_count,
    output logic             mem_enable,
    output logic             mem_write,
    output logic [20:0]      mem_address,
    output logic [7:0]       mem_wdata,
    input  logic [7:0]       mem_rdata
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state, state_next;

    logic [UP_AW-1:0] fifo_addr [FIFO_DEPTH];
    logic [7:0]       fifo_data [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count;

    logic fifo_empty, fifo_full, accepting, pop, push, drop, session_start;

    assign fifo_empty    = (count == '0);
    assign fifo_full     = (count == CW'(FIFO_DEPTH));
    assign accepting     = (state == S_LOAD) || (state == S_DRAIN);
    // The FIFO head goes out in any cycle the CPU leaves the port free.
    assign pop           = !cpu_enable && !fifo_empty;
    // A full FIFO still takes a byte when the head leaves in the same cycle.
    assign push          = up_strobe && accepting && (!fifo_full || pop);
    assign drop          = up_strobe && accepting && fifo_full && !pop;
    assign session_start = (state == S_IDLE) && up_active;

    assign cpu_hold = accepting;
    assign up_done  = (state == S_DONE);

    // Port mux: CPU first, then the FIFO head, otherwise a quiet bus.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        mem_enable  = 1'b0;
        mem_write   = 1'b0;
        mem_address = '0;
        mem_wdata   = '0;
        if (cpu_enable) begin
            mem_enable  = 1'b1;
            mem_write   = cpu_write;
            mem_address = cpu_address;
            mem_wdata   = cpu_wdata;
        end else if (pop) begin
            mem_enable  = 1'b1;
            mem_write   = 1'b1;
            mem_address = UPLOAD_BASE + 21'(fifo_addr[rd_ptr]);
            mem_wdata   = fifo_data[rd_ptr];
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (up_active) state_next = S_LOAD;
            S_LOAD:  if (!up_active) state_next = S_DRAIN;
            S_DRAIN: begin
                if (up_active)                state_next = S_LOAD;
                else if (fifo_empty && !push) state_next = S_DONE;
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge bus_clk or negedge bus_reset_n) begin
        if (!bus_reset_n) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            state       <= S_IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            up_count    <= '0;
            up_overflow <= 1'b0;
            cpu_rdata   <= '0;
        end else begin
            state     <= state_next;
            cpu_rdata <= (cpu_enable && !cpu_write) ? mem_rdata : 8'h00;

            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            if (session_start) up_count <= '0;
            else if (pop)      up_count <= up_count + 21'd1;

            if (session_start) up_overflow <= 1'b0;
            else if (drop)     up_overflow <= 1'b1;
        end
    end

    // NOTE: the FIFO storage has no reset; emptiness is tracked by the reset
    // pointers and count, so stale entries are never read.
    always_ff @(posedge bus_clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= up_addr;
            fifo_data[wr_ptr] <= up_data;
        end
    end

endmodule

// File: doc/sdram_port_arbiter.md
# sdram_port_arbiter

Shares the single byte-wide SDRAM port between the HC800 CPU RAM bus and the program uploader (data_io byte stream). CPU accesses always win and keep their one-cycle read latency. Upload writes are buffered in a small FIFO and drained into idle bus cycles. The block also sequences the upload session and holds the CPU off the bus until every uploaded byte has been committed.

## Interface
Parameters:
- UP_AW, 12: uploader address width; zero-extended to 21 bits.
- UPLOAD_BASE, 21'h000000: SDRAM byte address that receives upload offset 0.
- FIFO_DEPTH, 4: upload write buffer entries; power of two, range 2..16.

Ports:
- bus_clk  in  1  bus clock (13.5 MHz domain); all logic on its rising edge.
- bus_reset_n  in  1  asynchronous, active-low reset.
- cpu_enable  in  1  CPU RAM bus cycle request, one cycle per access.
- cpu_write  in  1  1 = write, 0 = read; qualified by cpu_enable.
- cpu_address  in  21  CPU byte address.
- cpu_wdata  in  8  CPU write data.
- cpu_rdata  out  8  registered read data; 0 when no read was issued in the previous cycle.
- cpu_hold  out  1  requests CPU reset/hold while an upload is in progress or pending.
- up_active  in  1  level, high for the whole upload session; already synchronised to bus_clk.
- up_strobe  in  1  one-cycle pulse qualifying a single upload byte.
- up_addr  in  UP_AW  upload byte offset.
- up_data  in  8  upload byte.
- up_overflow  out  1  sticky flag: an upload byte was dropped.
- up_done  out  1  one-cycle pulse when the session has fully drained.
- up_count  out  21  bytes committed to SDRAM in the current session; wraps at 2^21.
- mem_enable  out  1  SDRAM access request (combinational).
- mem_write  out  1  SDRAM write (combinational).
- mem_address  out  21  SDRAM byte address (combinational).
- mem_wdata  out  8  SDRAM write data (combinational).
- mem_rdata  in  8  SDRAM low-byte read data for the access issued this cycle.

## Operation
Grant, evaluated every cycle:
- If cpu_enable = 1, the CPU owns the port. mem_* pass through the cpu_* inputs.
- Else, if the FIFO is not empty, the FIFO head is issued with mem_enable=1 and mem_write=1. The address is (UPLOAD_BASE + head offset) mod 2^21. The head pops at the clock edge and up_count increments.
- Else mem_enable=0 and the other mem_* outputs are 0.

Read data:
- cpu_rdata <= (cpu_enable & !cpu_write) ? mem_rdata : 0, on every edge.

FIFO:
- An up_strobe pushes {up_addr, up_data}. The push is accepted when count < FIFO_DEPTH, or when the FIFO is full and a pop happens in the same cycle.
- A push and a pop in the same cycle leave the count unchanged.
- A strobe that arrives while the FIFO is full with no pop is dropped, and up_overflow is set. up_overflow clears only on the next up_active rising edge.
- Strobes are ignored (neither pushed nor flagged) while the FSM is in IDLE or DONE.

Session FSM states: IDLE, LOAD, DRAIN, DONE.
- IDLE -> LOAD on up_active = 1. This clears up_count and up_overflow.
- LOAD -> DRAIN on up_active = 0.
- DRAIN -> DONE when the FIFO is empty and no push is pending. An immediate transition is allowed if the FIFO is already empty.
- DONE -> IDLE after exactly one cycle. up_done = 1 only in DONE.
- If up_active rises again while in DRAIN, the FSM returns to LOAD. The FIFO contents are kept, and up_count and up_overflow are not cleared.
- cpu_hold = 1 in LOAD and DRAIN, 0 in IDLE and DONE.

Reset:
- Asynchronous. The FSM goes to IDLE and the FIFO empties; in-flight entries are discarded.
- All registered outputs go to 0: cpu_rdata=0, cpu_hold=0, up_overflow=0, up_done=0, up_count=0.
- During reset mem_enable=0, because the FIFO is empty. It can only be 1 if cpu_enable is driven.

## Timing
- CPU read: address and enable in cycle N; data on cpu_rdata after edge N+1. This latency is identical with or without upload traffic.
- CPU write: committed in the same cycle it is presented; never delayed.
- Upload write latency: from strobe edge to mem issue is at least 1 cycle (earliest is the cycle after the push). It is unbounded while the CPU holds the bus every cycle.
- up_count updates on the pop edge.
- up_done asserts at least 2 cycles after up_active falls.
- cpu_hold rises on the edge that samples up_active = 1, and falls on the edge entering DONE.

## Test plan
- Reset with up_active = 0 -> all outputs 0, mem_enable = 0. CPU write 0x5A to 0x000100, then read it with mem_rdata = 0x5A -> cpu_rdata = 0x5A exactly one cycle after the read; cpu_rdata = 0 on the following idle cycle.
- UPLOAD_BASE = 0x010000, upload of 8 bytes at offsets 0..7 with strobes 3 cycles apart, no CPU traffic -> 8 writes at 0x010000..0x010007 in order; up_count = 8; cpu_hold high throughout; a single up_done pulse.
- Upload strobe in the same cycle as a CPU read -> the CPU is served that cycle and the upload write is issued in the next free cycle. The CPU read data is unaffected.
- FIFO_DEPTH = 4, CPU enabled for 10 consecutive cycles while 6 strobes arrive -> the first 4 are buffered, the 5th and 6th are dropped, up_overflow = 1. After the CPU releases, 4 writes drain, up_count = 4, and up_overflow stays set until the next session.
- FIFO full, with a strobe in the same cycle as a pop -> the new byte is accepted, no overflow, count remains 4.
- bus_reset_n pulled low in DRAIN with 3 entries queued -> no further mem writes, cpu_hold = 0 immediately, state IDLE, and no up_done pulse.
